alu_mdu: RTL and testbench

Parametrised execution unit for the pipelined MIPS core. It combines a single-cycle integer ALU with an iterative multiply/divide engine that writes HI/LO. The ALU path extends the original add/sub/logic/slt/sll set with XOR, NOR, SLTU, and variable logical and arithmetic right shifts. The mul/div path runs a multi-cycle start/busy/done handshake alongside the ALU and is consumed by the hazard unit (stall on busy) and by MFHI/MFLO forwarding.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/mdu_iter.sv | 135 +++++++++++++
 rtl/alu_mdu.sv | 72 +++++++
 tb/tb_alu_mdu.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op encoding, mul/div FSM states and op-class helper for the MIPS
// execution unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SLL   = 4'b0011,
    OP_SRL   = 4'b0100,
    OP_SRA   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_SLTU  = 4'b1000,
    OP_XOR   = 4'b1001,
    OP_NOR   = 4'b1010,
    OP_RSVD  = 4'b1011,
    OP_MULT  = 4'b1100,
    OP_MULTU = 4'b1101,
    OP_DIV   = 4'b1110,
    OP_DIVU  = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } mdu_state_t;

  function automatic logic is_muldiv(input alu_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide engine: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, sign fix-up at the end, registered HI/LO.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  mdu_state_t           r_state;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opd;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_dz;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_signed;
  logic                 w_is_div;
  logic                 w_sa;
  logic                 w_sb;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_div_shift;
  logic [WIDTH:0]       w_div_trial;
  logic [2*WIDTH-1:0]   w_step;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_q_fix;
  logic [WIDTH-1:0]     w_r_fix;

  always_comb begin
    w_signed = (op == OP_MULT) || (op == OP_DIV);
    w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    w_sa     = w_signed & a[MSB];
    w_sb     = w_signed & b[MSB];
    w_a_mag  = w_sa ? (~a + 1'b1) : a;
    w_b_mag  = w_sb ? (~b + 1'b1) : b;
  end

  // Multiply: {high half, multiplier} shifts right; divide: {remainder, quotient} shifts left.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
    w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    w_div_trial = w_div_shift - {1'b0, r_opd};
    if (!r_is_div) begin
      w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    end else if (!w_div_trial[WIDTH]) begin
      w_step = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_step = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    w_prod_fix = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    w_q_fix    = r_dz ? {WIDTH{1'b1}} :
                 (r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0]);
    w_r_fix    = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= {CW{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_opd    <= {WIDTH{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && is_muldiv(op)) begin
            r_state  <= CALC;
            r_count  <= {CW{1'b0}};
            r_is_div <= w_is_div;
            r_opd    <= w_is_div ? w_b_mag : w_a_mag;
            r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_dz     <= w_is_div && (b == {WIDTH{1'b0}});
          end
        end
        CALC: begin
          r_acc   <= w_step;
          r_count <= r_count + 1'b1;
          if (r_count == CW'(WIDTH - 1)) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          if (r_is_div) begin
            r_hi <= w_r_fix;
            r_lo <= w_q_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: rtl/alu_mdu.sv
// MIPS execution unit: combinational integer ALU plus the iterative
// multiply/divide engine that owns HI/LO.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_result;
  logic             w_addsub;

  // SUB reuses the adder with the two's complement of b.
  always_comb begin
    w_addsub = (op == OP_ADD) || (op == OP_SUB);
    w_b_eff  = (op == OP_SUB) ? (~b + 1'b1) : b;
    w_sum    = a + w_b_eff;
    case (op)
      OP_AND:  w_result = a & b;
      OP_OR:   w_result = a | b;
      OP_ADD:  w_result = w_sum;
      OP_SUB:  w_result = w_sum;
      OP_SLL:  w_result = a << shamt;
      OP_SRL:  w_result = a >> shamt;
      OP_SRA:  w_result = $unsigned($signed(a) >>> shamt);
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  w_result = a ^ b;
      OP_NOR:  w_result = ~(a | b);
      default: w_result = {WIDTH{1'b0}};
    endcase
  end

  assign result   = w_result;
  assign zero     = (w_result == {WIDTH{1'b0}});
  assign overflow = w_addsub && (a[MSB] == w_b_eff[MSB]) && (w_sum[MSB] != a[MSB]);

  mdu_iter #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu at WIDTH=32.
module tb_alu_mdu;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  alu_op_t     op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        start;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op(op), .a(a), .b(b), .shamt(shamt),
    .start(start), .result(result), .zero(zero), .overflow(overflow),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one mul/div op (called #1 after an edge) and returns in the done cycle.
  task automatic run_md(input alu_op_t o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output bit busy_ok);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OP_AND;
    lat = 1; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = OP_AND; a = 32'h0; b = 32'h0; shamt = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
    n_tests++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    op = OP_ADD; a = 32'h7FFFFFFF; b = 32'h1; #1;
    n_tests++; if ({result, overflow, zero} !== {32'h80000000, 1'b1, 1'b0}) begin n_fail++;
      $display("FAIL add_ovf got %h ov=%b z=%b want 80000000 ov=1 z=0", result, overflow, zero); end
    op = OP_SUB; a = 32'd5; b = 32'd5; #1;
    n_tests++; if ({result, overflow, zero} !== {32'h0, 1'b0, 1'b1}) begin n_fail++;
      $display("FAIL sub_zero got %h ov=%b z=%b want 0 ov=0 z=1", result, overflow, zero); end
    op = OP_SUB; a = 32'h80000000; b = 32'd1; #1;
    n_tests++; if ({result, overflow} !== {32'h7FFFFFFF, 1'b1}) begin n_fail++;
      $display("FAIL sub_ovf got %h ov=%b want 7fffffff ov=1", result, overflow); end
    op = OP_SRA; a = 32'h80000000; shamt = 5'd4; #1;
    n_tests++; if (result !== 32'hF8000000) begin n_fail++; $display("FAIL sra got %h want f8000000", result); end
    op = OP_SRL; #1;
    n_tests++; if (result !== 32'h08000000) begin n_fail++; $display("FAIL srl got %h want 08000000", result); end
    op = OP_SLL; a = 32'h00000003; shamt = 5'd31; #1;
    n_tests++; if (result !== 32'h80000000) begin n_fail++; $display("FAIL sll got %h want 80000000", result); end
    op = OP_SLTU; a = 32'hFFFFFFFF; b = 32'd1; #1;
    n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL sltu got %h want 0", result); end
    op = OP_SLT; #1;
    n_tests++; if (result !== 32'd1) begin n_fail++; $display("FAIL slt got %h want 1", result); end
    op = OP_XOR; a = 32'hF0F0FFFF; b = 32'h0FF0F00F; #1;
    n_tests++; if (result !== 32'hFF000FF0) begin n_fail++; $display("FAIL xor got %h want ff000ff0", result); end
    op = OP_NOR; #1;
    n_tests++; if (result !== 32'h000F0000) begin n_fail++; $display("FAIL nor got %h want 000f0000", result); end
    op = OP_AND; #1;
    n_tests++; if (result !== 32'h00F0F00F) begin n_fail++; $display("FAIL and got %h want 00f0f00f", result); end
    op = OP_OR; #1;
    n_tests++; if (result !== 32'hFFF0FFFF || overflow !== 1'b0) begin n_fail++; $display("FAIL or got %h ov=%b want fff0ffff ov=0", result, overflow); end
    op = OP_RSVD; #1;
    n_tests++; if ({result, zero} !== {32'h0, 1'b1}) begin n_fail++; $display("FAIL rsvd got %h z=%b want 0 z=1", result, zero); end
    op = OP_MULT; #1;
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL muldiv_result got %h want 0", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int  lat;
    bit  bok;
    run_md(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, bok);
    n_tests++; if (lat !== 34) begin n_fail++; $display("FAIL mult_latency got %0d want 34", lat); end
    n_tests++; if (bok !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy window_ok=%b busy_at_done=%b want 1/0", bok, busy); end
    n_tests++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin n_fail++; $display("FAIL mult_hilo got %h want ffffffffffffffeb", {hi, lo}); end
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_width got %b want 0", done); end
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin n_fail++; $display("FAIL hilo_hold got %h want ffffffffffffffeb", {hi, lo}); end
    run_md(OP_MULTU, 32'hFFFFFFFF, 32'd2, lat, bok);
    n_tests++; if ({hi, lo} !== 64'h00000001_FFFFFFFE || lat !== 34) begin n_fail++;
      $display("FAIL multu got %h lat=%0d want 00000001fffffffe lat=34", {hi, lo}, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    int  lat;
    bit  bok;
    run_md(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bok);
    n_tests++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD || lat !== 34) begin n_fail++;
      $display("FAIL div_signed got %h lat=%0d want fffffffffffffffd lat=34", {hi, lo}, lat); end
    @(posedge clk); #1;
    run_md(OP_DIVU, 32'd9, 32'd0, lat, bok);
    n_tests++; if ({hi, lo} !== 64'h00000009_FFFFFFFF || lat !== 34) begin n_fail++;
      $display("FAIL divu_by_zero got %h lat=%0d want 00000009ffffffff lat=34", {hi, lo}, lat); end
    @(posedge clk); #1;
    run_md(OP_DIV, 32'hFFFFFFF9, 32'd0, lat, bok);
    n_tests++; if ({hi, lo} !== 64'hFFFFFFF9_FFFFFFFF) begin n_fail++;
      $display("FAIL div_neg_by_zero got %h want fffffff9ffffffff", {hi, lo}); end
    @(posedge clk); #1;
    run_md(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bok);
    n_tests++; if ({hi, lo} !== 64'h00000000_80000000) begin n_fail++;
      $display("FAIL div_min_neg1 got %h want 0000000080000000", {hi, lo}); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int  lat;
    bit  bok;
    op = OP_MULT; a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      if (lat == 5) begin op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1; end
      else begin start = 1'b0; end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    n_tests++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB || lat !== 34) begin n_fail++;
      $display("FAIL busy_start_ignored got %h lat=%0d want ffffffffffffffeb lat=34", {hi, lo}, lat); end
    run_md(OP_DIVU, 32'd100, 32'd7, lat, bok);
    n_tests++; if ({hi, lo} !== 64'h00000002_0000000E || lat !== 34 || bok !== 1'b1) begin n_fail++;
      $display("FAIL reissue_in_done got %h lat=%0d busy_ok=%b want 000000020000000e lat=34 busy_ok=1", {hi, lo}, lat, bok); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    int  lat;
    bit  bok;
    bit  quiet;
    op = OP_MULT; a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL midop_reset_busy got %b want 00", {busy, done}); end
    n_tests++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL midop_reset_hilo got %h want 0", {hi, lo}); end
    @(posedge clk); #1;
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    n_tests++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL post_reset_quiet got %b want 1", quiet); end
    run_md(OP_MULTU, 32'hFFFFFFFF, 32'd2, lat, bok);
    n_tests++; if ({hi, lo} !== 64'h00000001_FFFFFFFE || lat !== 34) begin n_fail++;
      $display("FAIL post_reset_op got %h lat=%0d want 00000001fffffffe lat=34", {hi, lo}, lat); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
